// File: rtl/cmd_pkg.sv
// Shared command-protocol definitions for the serial command decoder and the
// response transmitter that will sit beside it.
package cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam int         NUM_REGS  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_SYNC = 2'd1,
        GOT_ADDR = 2'd2,
        GOT_DATA = 2'd3
    } cmd_state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [7:0] data);
        return addr + data;
    endfunction

endpackage

// File: rtl/acia_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle strobe per good byte and a
// one-cycle error strobe when the stop bit is found low.
module acia_rx #(
    parameter int sym_cnt = 416,
    parameter int SCW     = $clog2(sym_cnt)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err
);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [SCW-1:0] LAST_TICK = SCW'(sym_cnt - 1);
    localparam logic [SCW-1:0] HALF_TICK = SCW'(sym_cnt / 2 - 1);

    rx_state_t      state, state_nxt;
    logic           rx_meta, rx_s, rx_prev;
    logic [SCW-1:0] tick, tick_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic [7:0]     dat_nxt;
    logic           stb_nxt, err_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_dat  <= '0;
            rx_stb  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            rx_dat  <= dat_nxt;
            rx_stb  <= stb_nxt;
            rx_err  <= err_nxt;
        end
    end

    // A start needs a real falling edge, so a line still held low after a
    // framing error cannot retrigger the receiver.
    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        dat_nxt     = rx_dat;
        stb_nxt     = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            RX_IDLE: begin
                tick_nxt = '0;
                if (rx_prev && !rx_s) state_nxt = RX_START;
            end
            RX_START: begin
                if (tick == HALF_TICK) begin
                    tick_nxt    = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick == LAST_TICK) begin
                    tick_nxt    = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick == LAST_TICK) begin
                    tick_nxt  = '0;
                    state_nxt = RX_IDLE;
                    if (rx_s) begin
                        stb_nxt = 1'b1;
                        dat_nxt = shreg;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/cmd_decoder.sv
// Serial command decoder: parses SYNC/ADDR/DATA/CSUM frames from the UART and
// writes four config registers or raises action commands.
module cmd_decoder
    import cmd_pkg::*;
#(
    parameter int CLK_FREQ    = 48000000,
    parameter int SYM_RATE    = 115200,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fpga_rx,
    output logic [31:0] cfg_regs,
    output logic        cmd_stb,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        frame_err
);

    localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
    localparam int SCW     = $clog2(SYM_CNT);
    localparam int TCW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] TMO_MAX = TCW'(TIMEOUT_CYC);

    cmd_state_t     state, state_nxt;
    logic [7:0]     rx_dat;
    logic           rx_stb, rx_err;
    logic [7:0]     frame_addr, frame_addr_nxt;
    logic [7:0]     frame_data, frame_data_nxt;
    logic [TCW-1:0] tmo_cnt, tmo_nxt;
    logic [31:0]    cfg_nxt;
    logic [7:0]     cmd_addr_nxt, cmd_data_nxt;
    logic           stb_nxt, err_nxt;

    acia_rx #(
        .sym_cnt (SYM_CNT),
        .SCW     (SCW)
    ) u_acia_rx (
        .clk    (clk),
        .reset  (~rst),
        .rx_in  (fpga_rx),
        .rx_dat (rx_dat),
        .rx_stb (rx_stb),
        .rx_err (rx_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            frame_addr <= '0;
            frame_data <= '0;
            tmo_cnt    <= '0;
            cfg_regs   <= '0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
            cmd_stb    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_addr <= frame_addr_nxt;
            frame_data <= frame_data_nxt;
            tmo_cnt    <= tmo_nxt;
            cfg_regs   <= cfg_nxt;
            cmd_addr   <= cmd_addr_nxt;
            cmd_data   <= cmd_data_nxt;
            cmd_stb    <= stb_nxt;
            frame_err  <= err_nxt;
        end
    end

    // Once synced, every byte is payload; only a framing error or the
    // inter-byte timeout can end a frame early.
    always_comb begin
        state_nxt      = state;
        frame_addr_nxt = frame_addr;
        frame_data_nxt = frame_data;
        tmo_nxt        = tmo_cnt;
        cfg_nxt        = cfg_regs;
        cmd_addr_nxt   = cmd_addr;
        cmd_data_nxt   = cmd_data;
        stb_nxt        = 1'b0;
        err_nxt        = 1'b0;

        if (state == IDLE || rx_stb)
            tmo_nxt = '0;
        else if (tmo_cnt != TMO_MAX)
            tmo_nxt = tmo_cnt + 1'b1;

        if (state == IDLE) begin
            if (rx_stb && rx_dat == SYNC_BYTE) state_nxt = GOT_SYNC;
        end else if (rx_err) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (rx_stb) begin
            case (state)
                GOT_SYNC: begin
                    frame_addr_nxt = rx_dat;
                    state_nxt      = GOT_ADDR;
                end
                GOT_ADDR: begin
                    frame_data_nxt = rx_dat;
                    state_nxt      = GOT_DATA;
                end
                default: begin
                    state_nxt = IDLE;
                    if (rx_dat != frame_csum(frame_addr, frame_data)) begin
                        err_nxt = 1'b1;
                    end else if (!frame_addr[7] && frame_addr[6:0] >= 7'(NUM_REGS)) begin
                        err_nxt = 1'b1;
                    end else begin
                        stb_nxt      = 1'b1;
                        cmd_addr_nxt = frame_addr;
                        cmd_data_nxt = frame_data;
                        if (!frame_addr[7])
                            cfg_nxt[{frame_addr[1:0], 3'b000} +: 8] = frame_data;
                    end
                end
            endcase
        end else if (tmo_cnt == TMO_MAX) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end
    end

endmodule
